// File: rtl/dac_sample_fifo.sv
// Stereo PCM sample FIFO feeding the DAC serializer: valid/ready writes, one pair per
// frame request, silence plus a sticky underrun flag when a request finds it empty.
module dac_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              sample_req,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  output logic [ADDR_W:0]   level,
  output logic              underrun,
  input  logic              clr_underrun
);

  localparam logic [ADDR_W:0] full_level = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] zero_level = '0;
  localparam logic [ADDR_W:0] one_level  = (ADDR_W + 1)'(1);

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]   wp;
  logic [ADDR_W-1:0]   rp;
  logic                wr_en;
  logic                rd_en;
  logic                empty_req;

  assign in_ready  = (level != full_level);
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = sample_req && (level != zero_level);
  // No bypass: a request that sees an empty FIFO underruns even if a write lands this edge.
  assign empty_req = sample_req && (level == zero_level);

  // NOTE: the storage array is not reset; its contents are don't-care until written,
  // and leaving it out of the reset keeps it a plain register file/RAM.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      mem[wp] <= {in_left, in_right};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      out_valid <= sample_req;

      if (wr_en) begin
        wp <= wp + ADDR_W'(1);
      end

      if (rd_en) begin
        {out_left, out_right} <= mem[rp];
        rp <= rp + ADDR_W'(1);
      end else if (empty_req) begin
        out_left  <= '0;
        out_right <= '0;
      end

      unique case ({wr_en, rd_en})
        2'b10:   level <= level + one_level;
        2'b01:   level <= level - one_level;
        default: level <= level;
      endcase

      // Set wins over a same-cycle clear.
      if (empty_req) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dac_sample_fifo.md
# dac_sample_fifo

Stereo sample buffer that sits directly upstream of the DAC serializer (`Digital_Audio_Interface`). It accepts left/right PCM sample pairs from a producer, such as a tone generator or a memory reader, through a valid/ready handshake. It stores them in a small circular FIFO and releases one pair per frame request from the serializer. When the FIFO is empty, it plays silence and latches a sticky underrun flag.

## Interface
Parameters:
- `DATA_W`, 16: bits per channel sample (two's complement).
- `DEPTH`, 16: FIFO depth in stereo pairs; must be a power of 2, ≥ 2.
- `ADDR_W`, 4: log2(`DEPTH`).

Ports:
- `clk`  in  1  single clock for the whole block; all state changes on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  producer holds a valid pair on `in_left`/`in_right`.
- `in_ready`  out  1  FIFO can accept a pair this cycle.
- `in_left`  in  `DATA_W`  left sample.
- `in_right`  in  `DATA_W`  right sample.
- `sample_req`  in  1  one-cycle pulse from the serializer requesting the next frame.
- `out_left`  out  `DATA_W`  left sample presented to the serializer.
- `out_right`  out  `DATA_W`  right sample presented to the serializer.
- `out_valid`  out  1  one-cycle pulse; `out_left`/`out_right` were updated in response to a request.
- `level`  out  `ADDR_W+1`  number of stored pairs, 0..`DEPTH`.
- `underrun`  out  1  sticky; set when a request finds the FIFO empty.
- `clr_underrun`  in  1  clears `underrun`.

## Operation
- **Storage:** `DEPTH` × (2·`DATA_W`) register array holding {left, right}. Write pointer `wp` and read pointer `rp` are `ADDR_W` bits and wrap modulo `DEPTH`. The level counter is `ADDR_W+1` bits.
- **Write:** a pair is accepted when `in_valid && in_ready`.
  - The pair is stored at `wp`, and `wp` increments.
  - `in_ready` = (`level` != `DEPTH`), derived from the registered level, so it is combinational on state only.
- **Read:** on `sample_req`:
  - If `level` > 0: the pair at `rp` is loaded into `out_left`/`out_right`, and `rp` increments.
  - If `level` == 0: `out_left`/`out_right` are loaded with 0, `underrun` is set, and pointers are unchanged.
  - `out_valid` pulses in both cases.
- **Level update:** `level` += accepted write, −= successful read. A simultaneous write and read leaves `level` unchanged.
- **Empty with simultaneous write and request:** no bypass. The request underruns (outputs 0, flag set), and the written pair is stored, giving `level` = 1.
- **Full:** `in_ready` = 0, so no write occurs. A request in the same cycle frees one slot; `in_ready` rises the following cycle.
- **Output hold:** `out_left`/`out_right` hold their value between requests. The serializer samples them at any time.
- **Back-to-back requests:** `sample_req` may be asserted on consecutive cycles. Each request is serviced independently.
- **Underrun flag:** `clr_underrun` clears `underrun`. If a set and a clear occur in the same cycle, set wins.
- **Reset** (`reset_n` = 0 at an edge):
  - `wp`, `rp`, `level` = 0.
  - `out_left`, `out_right` = 0.
  - `out_valid` = 0, `underrun` = 0.
  - `in_ready` = 1 the cycle after reset is deasserted.
  - Array contents are don't-care.
  - Reset mid-operation discards all stored pairs; any handshake in progress in that cycle is ignored.

## Timing
- **Write acceptance:** a pair offered in cycle N is accepted at edge N if `in_ready` is high in N; `level` reflects it in N+1.
- **Read latency:** 1 cycle. `sample_req` in cycle N gives `out_left`/`out_right`/`out_valid` updated at edge N, visible in N+1.
- **`out_valid` width:** exactly 1 cycle per request; never asserted without a request.
- **`underrun` timing:** visible in the cycle after the failing request.
- **Throughput:** one write and one read per cycle sustained.

## Test plan
- **Reset values:** hold `reset_n` = 0 for 2 cycles, then release → `level` = 0, `in_ready` = 1, `out_left` = `out_right` = 0, `underrun` = 0, `out_valid` = 0.
- **Write then read in order:** write pairs (0x0001, 0x8001), (0x0002, 0x8002), (0x0003, 0x8003); then pulse `sample_req` three times → outputs appear in write order, each one cycle after its request; `level` goes 3→2→1→0.
- **Fill and wrap-around:** write 16 pairs → `level` = 16 and `in_ready` = 0; a further `in_valid` is not accepted. Issue 1 request → `in_ready` = 1 the next cycle. Write pair 17, drain all 16 → data order is intact across the pointer wrap.
- **Underrun with simultaneous write:** with an empty FIFO, assert `sample_req` and a write of (0x1234, 0x5678) in the same cycle → outputs = 0, `underrun` = 1, `level` = 1. The next request returns (0x1234, 0x5678).
- **Sticky flag, set priority:** with `underrun` = 1, assert `clr_underrun` alone → flag clears. On an empty FIFO, assert `clr_underrun` together with `sample_req` → `underrun` = 1.
- **Reset mid-stream:** with `level` = 5, assert `reset_n` = 0 for one cycle together with a write → `level` = 0 afterwards. The next request underruns with outputs 0.
